// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with sync flush and optional 2-entry skid buffer
module pipe_stage_skid #(
    parameter int DATA_W = 40,
    parameter int CTRL_W = 4,
    parameter bit SKID = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} stateE;
    stateE state, nextState;
    logic readyReg, accept, deliver, loadIn, loadSkid, moveSkid;
    logic [CTRL_W-1:0] mCtrl, sCtrl;
    logic [DATA_W-1:0] mData, sData;
    assign out_valid = state != EMPTY;
    assign in_ready = SKID ? readyReg : (~out_valid | out_ready);
    assign accept = in_valid & in_ready;
    assign deliver = out_valid & out_ready;
    assign out_ctrl = out_valid ? mCtrl : '0;
    assign out_data = mData;
    assign occupancy = state;
    always_comb begin
        nextState = state;
        loadIn = 1'b0;
        loadSkid = 1'b0;
        moveSkid = 1'b0;
        if (flush) nextState = EMPTY;
        else if (state == EMPTY) begin
            loadIn = accept;
            nextState = accept ? ONE : EMPTY;
        end else if (state == ONE) begin
            loadIn = accept & deliver;
            loadSkid = SKID & accept & ~deliver;
            nextState = loadSkid ? FULL : (deliver & ~accept) ? EMPTY : ONE;
        end else begin
            moveSkid = deliver;
            nextState = deliver ? ONE : FULL;
        end
    end
    // in_ready is registered from the next state so upstream never sees a combinational path
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            readyReg <= 1'b1;
        end else begin
            state <= nextState;
            readyReg <= nextState != FULL;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mCtrl <= '0;
            mData <= '0;
            sCtrl <= '0;
            sData <= '0;
        end else begin
            if (loadIn) begin
                mCtrl <= in_ctrl;
                mData <= in_data;
            end else if (moveSkid) begin
                mCtrl <= sCtrl;
                mData <= sData;
            end
            if (loadSkid) begin
                sCtrl <= in_ctrl;
                sData <= in_data;
            end
        end
    end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed and randomized checks of pipe_stage_skid (SKID=1 and SKID=0) against a queue model
module tb_pipe_stage_skid;
    localparam int DW = 40;
    localparam int CW = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic flush, inValid, inReady, outValid, outReady;
    logic [CW-1:0] inCtrl, outCtrl;
    logic [DW-1:0] inData, outData;
    logic [1:0] occ;
    logic flush0, inValid0, inReady0, outValid0, outReady0;
    logic [CW-1:0] inCtrl0, outCtrl0;
    logic [DW-1:0] inData0, outData0;
    logic [1:0] occ0;
    int nCmp = 0;
    int nErr = 0;
    logic [CW+DW-1:0] q[$];
    logic [CW+DW-1:0] q0[$];

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1)) dutSkid (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_ready(inReady),
        .in_ctrl(inCtrl), .in_data(inData), .out_valid(outValid), .out_ready(outReady),
        .out_ctrl(outCtrl), .out_data(outData), .occupancy(occ));

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0)) dutReg (
        .clk(clk), .rst(rst), .flush(flush0), .in_valid(inValid0), .in_ready(inReady0),
        .in_ctrl(inCtrl0), .in_data(inData0), .out_valid(outValid0), .out_ready(outReady0),
        .out_ctrl(outCtrl0), .out_data(outData0), .occupancy(occ0));

    // Model: a FIFO of held entries; SKID=1 holds up to 2, SKID=0 accepts only when empty or draining
    task automatic advance();
        bit acc, del, acc0, del0;
        acc = inValid && q.size() < 2;
        del = q.size() != 0 && outReady;
        acc0 = inValid0 && (q0.size() == 0 || outReady0);
        del0 = q0.size() != 0 && outReady0;
        @(posedge clk);
        if (rst || flush) q.delete();
        else begin
            if (del) void'(q.pop_front());
            if (acc) q.push_back({inCtrl, inData});
        end
        if (rst || flush0) q0.delete();
        else begin
            if (del0) void'(q0.pop_front());
            if (acc0) q0.push_back({inCtrl0, inData0});
        end
        #1;
    endtask

    task automatic test_reset();
        repeat (2) advance();
        nCmp++;
        if (outValid !== 1'b0 || outCtrl !== '0 || outData !== '0 || occ !== 2'd0 || inReady !== 1'b1) begin
            nErr++;
            $display("FAIL reset_state: valid=%b ctrl=%h data=%h occ=%0d ready=%b, want 0 0 0 0 1",
                     outValid, outCtrl, outData, occ, inReady);
        end
        nCmp++;
        if (outValid0 !== 1'b0 || occ0 !== 2'd0 || inReady0 !== 1'b1) begin
            nErr++;
            $display("FAIL reset_state_noskid: valid=%b occ=%0d ready=%b, want 0 0 1", outValid0, occ0, inReady0);
        end
        rst = 1'b0;
        outReady = 1'b0;
        inValid = 1'b1;
        inCtrl = 4'h6;
        inData = 40'h1;
        advance();
        inData = 40'h2;
        advance();
        inValid = 1'b0;
        #4;
        nCmp++;
        if (occ !== 2'd2) begin
            nErr++;
            $display("FAIL reset_fill: occ=%0d, want 2", occ);
        end
        rst = 1'b1;
        #1;
        nCmp++;
        if (outValid !== 1'b0 || outCtrl !== '0 || occ !== 2'd0 || inReady !== 1'b1) begin
            nErr++;
            $display("FAIL reset_async: valid=%b ctrl=%h occ=%0d ready=%b, want 0 0 0 1", outValid, outCtrl, occ, inReady);
        end
        advance();
        rst = 1'b0;
    endtask

    task automatic test_streaming();
        outReady = 1'b1;
        inCtrl = 4'hF;
        for (int i = 0; i <= 10; i++) begin
            inValid = i < 10;
            inData = DW'(i);
            #4;
            nCmp++;
            if (inReady !== 1'b1) begin
                nErr++;
                $display("FAIL stream_ready[%0d]: ready=%b, want 1", i, inReady);
            end
            nCmp++;
            if (i == 0 ? outValid !== 1'b0
                       : (outValid !== 1'b1 || outCtrl !== 4'hF || outData !== DW'(i - 1))) begin
                nErr++;
                $display("FAIL stream_out[%0d]: valid=%b ctrl=%h data=%h, want %b F %h",
                         i, outValid, outCtrl, outData, i != 0, i - 1);
            end
            advance();
        end
        inValid = 1'b0;
        #4;
        nCmp++;
        if (outValid !== 1'b0 || outCtrl !== '0) begin
            nErr++;
            $display("FAIL stream_drain: valid=%b ctrl=%h, want 0 0", outValid, outCtrl);
        end
        advance();
    endtask

    task automatic test_stall_skid();
        outReady = 1'b0;
        inValid = 1'b1;
        inCtrl = 4'h1;
        inData = 40'h1234;
        advance();
        inData = 40'h5678;
        #4;
        nCmp++;
        if (occ !== 2'd1 || outData !== 40'h1234 || inReady !== 1'b1) begin
            nErr++;
            $display("FAIL stall_one: occ=%0d data=%h ready=%b, want 1 1234 1", occ, outData, inReady);
        end
        advance();
        inValid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #4;
            nCmp++;
            if (occ !== 2'd2 || inReady !== 1'b0 || outValid !== 1'b1 || outData !== 40'h1234 || outCtrl !== 4'h1) begin
                nErr++;
                $display("FAIL stall_full[%0d]: occ=%0d ready=%b valid=%b data=%h ctrl=%h, want 2 0 1 1234 1",
                         k, occ, inReady, outValid, outData, outCtrl);
            end
            advance();
        end
        outReady = 1'b1;
        #4;
        nCmp++;
        if (outValid !== 1'b1 || outData !== 40'h1234) begin
            nErr++;
            $display("FAIL release_a: valid=%b data=%h, want 1 1234", outValid, outData);
        end
        advance();
        #4;
        nCmp++;
        if (outValid !== 1'b1 || outData !== 40'h5678 || occ !== 2'd1 || inReady !== 1'b1) begin
            nErr++;
            $display("FAIL release_b: valid=%b data=%h occ=%0d ready=%b, want 1 5678 1 1", outValid, outData, occ, inReady);
        end
        advance();
        #4;
        nCmp++;
        if (outValid !== 1'b0 || outCtrl !== '0 || occ !== 2'd0) begin
            nErr++;
            $display("FAIL release_empty: valid=%b ctrl=%h occ=%0d, want 0 0 0", outValid, outCtrl, occ);
        end
        advance();
    endtask

    task automatic test_flush();
        outReady = 1'b0;
        inValid = 1'b1;
        inCtrl = 4'h3;
        inData = 40'hAAAA;
        advance();
        inCtrl = 4'h5;
        inData = 40'hBBBB;
        advance();
        inCtrl = 4'h7;
        inData = 40'hCCCC;
        flush = 1'b1;
        #4;
        nCmp++;
        if (occ !== 2'd2) begin
            nErr++;
            $display("FAIL flush_fill: occ=%0d, want 2", occ);
        end
        advance();
        flush = 1'b0;
        inValid = 1'b0;
        outReady = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #4;
            nCmp++;
            if (outValid !== 1'b0 || outCtrl !== '0 || occ !== 2'd0 || inReady !== 1'b1) begin
                nErr++;
                $display("FAIL flush_full[%0d]: valid=%b ctrl=%h occ=%0d ready=%b, want 0 0 0 1",
                         k, outValid, outCtrl, occ, inReady);
            end
            advance();
        end
        outReady = 1'b0;
        inValid = 1'b1;
        inCtrl = 4'h9;
        inData = 40'hDDDD;
        advance();
        flush = 1'b1;
        inCtrl = 4'hE;
        inData = 40'hEEEE;
        advance();
        flush = 1'b0;
        inValid = 1'b0;
        outReady = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #4;
            nCmp++;
            if (outValid !== 1'b0 || outCtrl !== '0 || occ !== 2'd0) begin
                nErr++;
                $display("FAIL flush_accept[%0d]: valid=%b ctrl=%h occ=%0d, want 0 0 0", k, outValid, outCtrl, occ);
            end
            advance();
        end
    endtask

    task automatic test_noskid();
        outReady0 = 1'b0;
        inValid0 = 1'b1;
        inCtrl0 = 4'h2;
        inData0 = 40'h11;
        advance();
        inValid0 = 1'b0;
        #1;
        nCmp++;
        if (outValid0 !== 1'b1 || inReady0 !== 1'b0 || outData0 !== 40'h11 || occ0 !== 2'd1) begin
            nErr++;
            $display("FAIL noskid_stall: valid=%b ready=%b data=%h occ=%0d, want 1 0 11 1", outValid0, inReady0, outData0, occ0);
        end
        outReady0 = 1'b1;
        #1;
        nCmp++;
        if (inReady0 !== 1'b1) begin
            nErr++;
            $display("FAIL noskid_comb_ready: ready=%b, want 1", inReady0);
        end
        inValid0 = 1'b1;
        inData0 = 40'h22;
        advance();
        nCmp++;
        if (outValid0 !== 1'b1 || outData0 !== 40'h22 || occ0 !== 2'd1) begin
            nErr++;
            $display("FAIL noskid_replace1: valid=%b data=%h occ=%0d, want 1 22 1", outValid0, outData0, occ0);
        end
        inData0 = 40'h33;
        advance();
        nCmp++;
        if (outValid0 !== 1'b1 || outData0 !== 40'h33) begin
            nErr++;
            $display("FAIL noskid_replace2: valid=%b data=%h, want 1 33", outValid0, outData0);
        end
        inValid0 = 1'b0;
        advance();
        nCmp++;
        if (outValid0 !== 1'b0 || outCtrl0 !== '0 || occ0 !== 2'd0) begin
            nErr++;
            $display("FAIL noskid_empty: valid=%b ctrl=%h occ=%0d, want 0 0 0", outValid0, outCtrl0, occ0);
        end
    endtask

    task automatic test_random();
        logic [CW+DW-1:0] front, front0;
        bit ev, er, ev0, er0;
        for (int c = 0; c < 10000; c++) begin
            inValid = $urandom_range(0, 3) != 0;
            outReady = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 49) == 0;
            inCtrl = CW'($urandom);
            inData = {8'($urandom), $urandom};
            inValid0 = $urandom_range(0, 3) != 0;
            outReady0 = $urandom_range(0, 3) != 0;
            flush0 = $urandom_range(0, 49) == 0;
            inCtrl0 = CW'($urandom);
            inData0 = {8'($urandom), $urandom};
            #4;
            ev = q.size() != 0;
            er = q.size() < 2;
            front = '0;
            if (ev) front = q[0];
            nCmp++;
            if (outValid !== ev || inReady !== er || occ !== 2'(q.size())
                || (ev ? {outCtrl, outData} !== front : outCtrl !== '0)) begin
                nErr++;
                $display("FAIL rand_skid[%0d]: valid=%b ready=%b occ=%0d out=%h, want %b %b %0d %h",
                         c, outValid, inReady, occ, {outCtrl, outData}, ev, er, q.size(), front);
            end
            ev0 = q0.size() != 0;
            er0 = !ev0 || outReady0;
            front0 = '0;
            if (ev0) front0 = q0[0];
            nCmp++;
            if (outValid0 !== ev0 || inReady0 !== er0 || occ0 !== 2'(q0.size())
                || (ev0 ? {outCtrl0, outData0} !== front0 : outCtrl0 !== '0)) begin
                nErr++;
                $display("FAIL rand_noskid[%0d]: valid=%b ready=%b occ=%0d out=%h, want %b %b %0d %h",
                         c, outValid0, inReady0, occ0, {outCtrl0, outData0}, ev0, er0, q0.size(), front0);
            end
            advance();
        end
    endtask

    initial begin
        flush = 1'b0;
        inValid = 1'b0;
        inCtrl = '0;
        inData = '0;
        outReady = 1'b0;
        flush0 = 1'b0;
        inValid0 = 1'b0;
        inCtrl0 = '0;
        inData0 = '0;
        outReady0 = 1'b0;
        test_reset();
        test_streaming();
        test_stall_skid();
        test_flush();
        test_noskid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
